// File: rtl/rtc_timer_bcd_if.sv
// rtc_timer_bcd_if: user controls and display-facing outputs of the RTC/timer core.
//
// Signals
//   cursor                 edit-mode enable (level), also shown by the display
//   btn_next, btn_prev     single-cycle pulses, move the edit field
//   btn_inc, btn_dec       single-cycle pulses, modify the selected field
//   tmr_start              single-cycle pulse, arms the countdown
//   rsw                    ring silence switch (level)
//   dir                    selected field 0..8 (day, month, year, hour, min, sec, T-h, T-m, T-s)
//   *_d / *_u              BCD tens / units digits of every field
//   tmr_run                countdown active
//   ring                   alarm flag
//
// Modports
//   master  the controlling side: drives buttons, reads digits
//   slave   the timekeeping core
interface rtc_timer_bcd_if;
    logic       cursor;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_inc;
    logic       btn_dec;
    logic       tmr_start;
    logic       rsw;

    logic [3:0] dir;
    logic [3:0] fecha_d;
    logic [3:0] fecha_u;
    logic [3:0] mes_d;
    logic [3:0] mes_u;
    logic [3:0] ano_d;
    logic [3:0] ano_u;
    logic [3:0] H_hora_d;
    logic [3:0] H_hora_u;
    logic [3:0] H_min_d;
    logic [3:0] H_min_u;
    logic [3:0] H_seg_d;
    logic [3:0] H_seg_u;
    logic [3:0] T_hora_d;
    logic [3:0] T_hora_u;
    logic [3:0] T_min_d;
    logic [3:0] T_min_u;
    logic [3:0] T_seg_d;
    logic [3:0] T_seg_u;
    logic       tmr_run;
    logic       ring;

    modport master (
        output cursor, btn_next, btn_prev, btn_inc, btn_dec, tmr_start, rsw,
        input  dir, fecha_d, fecha_u, mes_d, mes_u, ano_d, ano_u,
        input  H_hora_d, H_hora_u, H_min_d, H_min_u, H_seg_d, H_seg_u,
        input  T_hora_d, T_hora_u, T_min_d, T_min_u, T_seg_d, T_seg_u,
        input  tmr_run, ring
    );

    modport slave (
        input  cursor, btn_next, btn_prev, btn_inc, btn_dec, tmr_start, rsw,
        output dir, fecha_d, fecha_u, mes_d, mes_u, ano_d, ano_u,
        output H_hora_d, H_hora_u, H_min_d, H_min_u, H_seg_d, H_seg_u,
        output T_hora_d, T_hora_u, T_min_d, T_min_u, T_seg_d, T_seg_u,
        output tmr_run, ring
    );
endinterface

// File: rtl/rtc_timer_bcd.sv
// rtc_timer_bcd: calendar (DD/MM/20YY), time of day (HH:MM:SS) and a countdown timer, all kept
// as packed BCD, with a field cursor for user editing and a one-second countdown alarm.
//
// Parameters
//   CLK_HZ   input clock frequency; the one-second prescaler wraps at CLK_HZ-1
//
// Ports
//   clk_i    system clock
//   rst_n    asynchronous active-low reset
//   rtc      rtc_timer_bcd_if.slave: buttons/switches in, digits/dir/tmr_run/ring out
//
// Build option
//   RTC_LEAP_YEAR_EN  when defined, February has 29 days in years divisible by 4;
//                     otherwise February always has 28 days.
//
// Every field is held as one byte {tens, units}. Valid BCD bytes order the same way as the
// numbers they encode, so plain unsigned compares are used for range tests.
module rtc_timer_bcd #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input logic            clk_i,
    input logic            rst_n,
    rtc_timer_bcd_if.slave rtc
);

    localparam int unsigned     PreW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(CLK_HZ - 1);

    localparam logic [3:0] DirDay   = 4'd0;
    localparam logic [3:0] DirMon   = 4'd1;
    localparam logic [3:0] DirYear  = 4'd2;
    localparam logic [3:0] DirHour  = 4'd3;
    localparam logic [3:0] DirMin   = 4'd4;
    localparam logic [3:0] DirSec   = 4'd5;
    localparam logic [3:0] DirTHour = 4'd6;
    localparam logic [3:0] DirTMin  = 4'd7;
    localparam logic [3:0] DirTSec  = 4'd8;

    // One BCD step up or down, wrapping inside [lo, hi] without any carry out.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic up);
        logic [7:0] r;
        if (up) begin
            if (v >= hi) begin
                r = lo;
            end else if (v[3:0] == 4'd9) begin
                r = {v[7:4] + 4'd1, 4'd0};
            end else begin
                r = {v[7:4], v[3:0] + 4'd1};
            end
        end else begin
            if (v <= lo) begin
                r = hi;
            end else if (v[3:0] == 4'd0) begin
                r = {v[7:4] - 4'd1, 4'd9};
            end else begin
                r = {v[7:4], v[3:0] - 4'd1};
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] mon, input logic [7:0] feb);
        logic [7:0] d;
        case (mon)
            8'h02:                      d = feb;
            8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
            default:                    d = 8'h31;
        endcase
        return d;
    endfunction

    // State
    logic [PreW-1:0] pre_q, pre_d;
    logic [7:0]      day_q, mon_q, year_q, hour_q, min_q, sec_q;
    logic [7:0]      day_d, mon_d, year_d, hour_d, min_d, sec_d;
    logic [7:0]      t_hour_q, t_min_q, t_sec_q;
    logic [7:0]      t_hour_d, t_min_d, t_sec_d;
    logic [3:0]      dir_q, dir_d;
    logic            run_q, run_d;
    logic            ring_q, ring_d;

    // Combinational helpers
    logic       tick;
    logic       edit;
    logic       up;
    logic [7:0] day_n;
    logic [7:0] feb_q, feb_n;
    logic [7:0] max_q, max_n;
    logic       c_min, c_hour, c_day, c_mon, c_year;
    logic       t_zero, t_one, t_next_zero;
    logic       tmr_hit;

    // ------------------------------------------------------------------
    // One-second prescaler, free running
    // ------------------------------------------------------------------
    assign tick  = (pre_q == PreMax);
    assign pre_d = tick ? '0 : pre_q + PreW'(1);

    // A field edit needs exactly one of inc/dec; both together cancel.
    assign edit = rtc.cursor && (rtc.btn_inc ^ rtc.btn_dec);
    assign up   = rtc.btn_inc;

    // ------------------------------------------------------------------
    // February length: depends on the year being written this cycle (feb_n) so that a year
    // edit re-clamps the day immediately.
    // ------------------------------------------------------------------
`ifdef RTC_LEAP_YEAR_EN
    // 10*t + u is a multiple of 4 exactly when 2*t + u is.
    function automatic logic is_leap(input logic [7:0] y);
        logic l;
        if (y[4]) begin
            l = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        end else begin
            l = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
        end
        return l;
    endfunction

    assign feb_q = is_leap(year_q) ? 8'h29 : 8'h28;
    assign feb_n = is_leap(year_d) ? 8'h29 : 8'h28;
`else
    assign feb_q = 8'h28;
    assign feb_n = 8'h28;
`endif

    assign max_q = days_in_month(mon_q, feb_q);
    assign max_n = days_in_month(mon_d, feb_n);

    // ------------------------------------------------------------------
    // Calendar and time of day
    // ------------------------------------------------------------------
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        day_n  = day_q;
        mon_d  = mon_q;
        year_d = year_q;
        c_min  = 1'b0;
        c_hour = 1'b0;
        c_day  = 1'b0;
        c_mon  = 1'b0;
        c_year = 1'b0;
        if (!rtc.cursor) begin
            if (tick) begin
                c_min  = (sec_q == 8'h59);
                c_hour = c_min && (min_q == 8'h59);
                c_day  = c_hour && (hour_q == 8'h23);
                c_mon  = c_day && (day_q >= max_q);
                c_year = c_mon && (mon_q == 8'h12);
                sec_d  = bcd_step(sec_q, 8'h00, 8'h59, 1'b1);
                if (c_min)  min_d  = bcd_step(min_q, 8'h00, 8'h59, 1'b1);
                if (c_hour) hour_d = bcd_step(hour_q, 8'h00, 8'h23, 1'b1);
                if (c_day)  day_n  = bcd_step(day_q, 8'h01, max_q, 1'b1);
                if (c_mon)  mon_d  = bcd_step(mon_q, 8'h01, 8'h12, 1'b1);
                if (c_year) year_d = bcd_step(year_q, 8'h00, 8'h99, 1'b1);
            end
        end else if (edit) begin
            case (dir_q)
                DirDay:  day_n  = bcd_step(day_q, 8'h01, max_q, up);
                DirMon:  mon_d  = bcd_step(mon_q, 8'h01, 8'h12, up);
                DirYear: year_d = bcd_step(year_q, 8'h00, 8'h99, up);
                DirHour: hour_d = bcd_step(hour_q, 8'h00, 8'h23, up);
                DirMin:  min_d  = bcd_step(min_q, 8'h00, 8'h59, up);
                DirSec:  sec_d  = bcd_step(sec_q, 8'h00, 8'h59, up);
                default: ;
            endcase
        end
    end

    // Clamping every cycle is harmless: the day only exceeds the limit right after a month or
    // year change.
    assign day_d = (day_n > max_n) ? max_n : day_n;

    // ------------------------------------------------------------------
    // Countdown value
    // ------------------------------------------------------------------
    assign t_zero = (t_hour_q == 8'h00) && (t_min_q == 8'h00) && (t_sec_q == 8'h00);
    assign t_one  = (t_hour_q == 8'h00) && (t_min_q == 8'h00) && (t_sec_q == 8'h01);

    always_comb begin
        t_hour_d = t_hour_q;
        t_min_d  = t_min_q;
        t_sec_d  = t_sec_q;
        tmr_hit  = 1'b0;
        if (!rtc.cursor) begin
            if (tick && run_q) begin
                // A running timer edited down to zero simply expires on its next tick.
                if (t_zero) begin
                    tmr_hit = 1'b1;
                end else begin
                    tmr_hit = t_one;
                    t_sec_d = bcd_step(t_sec_q, 8'h00, 8'h59, 1'b0);
                    if (t_sec_q == 8'h00) begin
                        t_min_d = bcd_step(t_min_q, 8'h00, 8'h59, 1'b0);
                        if (t_min_q == 8'h00) begin
                            t_hour_d = bcd_step(t_hour_q, 8'h00, 8'h23, 1'b0);
                        end
                    end
                end
            end
        end else if (edit) begin
            case (dir_q)
                DirTHour: t_hour_d = bcd_step(t_hour_q, 8'h00, 8'h23, up);
                DirTMin:  t_min_d  = bcd_step(t_min_q, 8'h00, 8'h59, up);
                DirTSec:  t_sec_d  = bcd_step(t_sec_q, 8'h00, 8'h59, up);
                default: ;
            endcase
        end
    end

    assign t_next_zero = (t_hour_d == 8'h00) && (t_min_d == 8'h00) && (t_sec_d == 8'h00);

    // ------------------------------------------------------------------
    // Run / alarm flags. Later assignments take priority: silence beats start beats expiry.
    // ------------------------------------------------------------------
    always_comb begin
        run_d  = run_q;
        ring_d = ring_q;
        if (tmr_hit) begin
            run_d = 1'b0;
            if (!rtc.rsw) ring_d = 1'b1;
        end
        if (rtc.tmr_start) begin
            ring_d = 1'b0;
            // Judged on the value being written, so a start coinciding with expiry does not
            // re-arm an empty timer.
            if (!t_next_zero) run_d = 1'b1;
        end
        if (rtc.rsw) ring_d = 1'b0;
    end

    // ------------------------------------------------------------------
    // Field cursor
    // ------------------------------------------------------------------
    always_comb begin
        dir_d = dir_q;
        if (rtc.cursor && (rtc.btn_next ^ rtc.btn_prev)) begin
            if (rtc.btn_next) begin
                dir_d = (dir_q >= DirTSec) ? DirDay : dir_q + 4'd1;
            end else begin
                dir_d = (dir_q == DirDay) ? DirTSec : dir_q - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            day_q    <= 8'h01;
            mon_q    <= 8'h01;
            year_q   <= 8'h16;
            hour_q   <= 8'h00;
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            t_hour_q <= 8'h00;
            t_min_q  <= 8'h00;
            t_sec_q  <= 8'h00;
            dir_q    <= DirDay;
            run_q    <= 1'b0;
            ring_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            day_q    <= day_d;
            mon_q    <= mon_d;
            year_q   <= year_d;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            t_hour_q <= t_hour_d;
            t_min_q  <= t_min_d;
            t_sec_q  <= t_sec_d;
            dir_q    <= dir_d;
            run_q    <= run_d;
            ring_q   <= ring_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs straight from the registers
    // ------------------------------------------------------------------
    assign rtc.dir      = dir_q;
    assign rtc.fecha_d  = day_q[7:4];
    assign rtc.fecha_u  = day_q[3:0];
    assign rtc.mes_d    = mon_q[7:4];
    assign rtc.mes_u    = mon_q[3:0];
    assign rtc.ano_d    = year_q[7:4];
    assign rtc.ano_u    = year_q[3:0];
    assign rtc.H_hora_d = hour_q[7:4];
    assign rtc.H_hora_u = hour_q[3:0];
    assign rtc.H_min_d  = min_q[7:4];
    assign rtc.H_min_u  = min_q[3:0];
    assign rtc.H_seg_d  = sec_q[7:4];
    assign rtc.H_seg_u  = sec_q[3:0];
    assign rtc.T_hora_d = t_hour_q[7:4];
    assign rtc.T_hora_u = t_hour_q[3:0];
    assign rtc.T_min_d  = t_min_q[7:4];
    assign rtc.T_min_u  = t_min_q[3:0];
    assign rtc.T_seg_d  = t_sec_q[7:4];
    assign rtc.T_seg_u  = t_sec_q[3:0];
    assign rtc.tmr_run  = run_q;
    assign rtc.ring     = ring_q;

endmodule

// File: doc/rtc_timer_bcd.md
# rtc_timer_bcd

Timekeeping core for the VGA clock/timer display: maintains calendar date (DD/MM/20YY), time of day (HH:MM:SS) and a countdown timer, all as packed BCD digits. It handles user editing through a field cursor and a one-second countdown with an alarm flag. It sits directly upstream of the text generator, which consumes every digit output, the field selector `dir` and the cursor enable.

## Interface
- `CLK_HZ`, 100000000: input clock frequency; sets the one-second prescaler terminal count.
- `clk_i`  in  1  system clock (100 MHz on board).
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `cursor`  in  1  edit mode enable (level); also forwarded to the display.
- `btn_next`, `btn_prev`  in  1 each  single-cycle pulses (debounced upstream); move the edit field.
- `btn_inc`, `btn_dec`  in  1 each  single-cycle pulses; modify the selected field.
- `tmr_start`  in  1  single-cycle pulse; arm the countdown.
- `rsw`  in  1  ring silence switch (level).
- `dir`  out  4  selected field: 0 day, 1 month, 2 year, 3 hour, 4 min, 5 sec, 6 T-hour, 7 T-min, 8 T-sec.
- `fecha_d/u`, `mes_d/u`, `ano_d/u`, `H_hora_d/u`, `H_min_d/u`, `H_seg_d/u`, `T_hora_d/u`, `T_min_d/u`, `T_seg_d/u`  out  4 each  BCD digits (tens/units).
- `tmr_run`  out  1  countdown active.
- `ring`  out  1  alarm flag.

## Operation
- Prescaler: counts from 0 to CLK_HZ-1 and wraps; `tick` is high for 1 cycle at the terminal count. The prescaler runs continuously and is never cleared except by reset.
- Normal mode (`cursor`=0), on `tick`:
  - Clock: sec 59→00 carries to min; min 59→00 carries to hour; hour 23→00 carries to day.
  - Date: day max(month)→01 carries to month; month 12→01 carries to year; year 99→00 (no carry).
  - Month lengths: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb per Configuration.
- Countdown: on the same `tick`, if `tmr_run`=1 the timer decrements as one 24h value (T-sec 00→59 borrows from T-min, T-min 00→59 borrows from T-hour).
  - A decrement that reaches 00:00:00 clears `tmr_run` and sets `ring` in the same cycle.
- Edit mode (`cursor`=1): clock, date and countdown all hold; ticks are ignored.
  - `btn_next`: `dir` increments, 8→0 wrap. `btn_prev`: `dir` decrements, 0→8 wrap. Both pulses in the same cycle: no change.
  - `btn_inc` / `btn_dec` modify only the selected field, wrapping within its own range with no carry:
    - day 01..max(month)
    - month 01..12
    - year 00..99
    - hours 00..23
    - min/sec 00..59
    - T-fields use the same ranges.
  - `btn_inc` and `btn_dec` in the same cycle: no change.
  - After any month or year change, day is clamped to max(month) in the same cycle.
  - Buttons are ignored when `cursor`=0. `dir` holds its value across mode changes.
- `tmr_start`:
  - Sets `tmr_run`=1 if the timer is nonzero; no effect at 00:00:00.
  - Always clears `ring`.
  - Honoured in either mode, but counting only occurs when `cursor`=0.
- `ring` clears while `rsw`=1, and cannot set while `rsw`=1.

## Timing
- All outputs are registered. Digit updates are visible on the clock edge following the `tick` or button cycle (1-cycle latency).
- Reset values:
  - Date 01/01/16; time 00:00:00; timer 00:00:00.
  - `dir`=0, `tmr_run`=0, `ring`=0; prescaler=0.
- Reset asserted mid-count or mid-edit returns all state to reset values immediately (asynchronous).
- The first `tick` after reset occurs CLK_HZ cycles after release.
- Digits are never outside BCD 0-9 or their field range in any cycle.

## Configuration
- `RTC_LEAP_YEAR_EN` defined: February has 29 days when (year mod 4)==0 (years 2000-2099), otherwise 28.
- Undefined: February always has 28 days, and the leap logic is not synthesised.

## Test plan
All scenarios use CLK_HZ=4.
- Rollover: set 23:59:59 on 31/12/99, `cursor`=0, wait 1 tick → 00:00:00 on 01/01/00.
- Leap year: date 28/02/24, time 23:59:59, 1 tick → 29/02/24 with `RTC_LEAP_YEAR_EN` defined, 01/03/24 without it.
- Edit wrap and clamp:
  - `cursor`=1, `btn_prev` from `dir`=0 → `dir`=8.
  - Day 31, month 01, select month, `btn_inc` → month 02, day clamped to 28 or 29.
  - `btn_dec` on hour 00 → 23.
- Countdown: timer 00:00:02, `tmr_start` → `tmr_run`=1; after 2 ticks → 00:00:00, `tmr_run`=0, `ring`=1; `rsw`=1 → `ring`=0.
- Holds and no-ops:
  - `cursor`=1 across 5 ticks → all digits unchanged.
  - `btn_inc`+`btn_dec` in the same cycle → no change.
  - `tmr_start` at 00:00:00 → `tmr_run` stays 0.
- Async reset mid-countdown (timer 00:10:00, running) → all outputs at reset values before the next clock edge.
